// File: rtl/nios_pio_master.sv
// Avalon-MM initiator for the nios_pio register slave.
// Runs single local commands and periodically polls the input register.
module nios_pio_master #(
  parameter int READ_LATENCY = 1,
  parameter int POLL_PERIOD  = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_address,
  input  logic [31:0] cmd_writedata,
  output logic        rsp_valid,
  output logic [31:0] rsp_readdata,
  input  logic        poll_enable,
  output logic [7:0]  poll_data,
  output logic        change_pulse,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  localparam int CW = $clog2(POLL_PERIOD + 1);
  localparam logic [CW-1:0] RELOAD = CW'(POLL_PERIOD - 1);
  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t        state_q;
  state_t        state_d;
  logic [2:0]    lat_cnt;
  logic          is_poll;
  logic [CW-1:0] poll_cnt;
  logic          poll_pending;
  logic          sample_valid;
  logic          accept;
  logic          start_poll;
  logic          last_rd;

  assign last_rd = (state_q == READ) && (lat_cnt == LAT);

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    start_poll     = 1'b0;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    unique case (state_q)
      IDLE: begin
        cmd_ready = ~reset;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = cmd_write ? WRITE : READ;
        end else if (poll_pending) begin
          start_poll = 1'b1;
          state_d    = READ;
        end
      end
      WRITE: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        state_d        = IDLE;
      end
      READ: begin
        avm_chipselect = 1'b1;
        if (last_rd) state_d = is_poll ? IDLE : DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      lat_cnt       <= '0;
      is_poll       <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      rsp_readdata  <= '0;
      poll_data     <= '0;
      sample_valid  <= 1'b0;
      change_pulse  <= 1'b0;
      poll_cnt      <= RELOAD;
      poll_pending  <= 1'b0;
    end else begin
      state_q      <= state_d;
      change_pulse <= 1'b0;
      if (accept) begin
        avm_address   <= cmd_address;
        avm_writedata <= cmd_writedata;
        is_poll       <= 1'b0;
        lat_cnt       <= '0;
      end else if (start_poll) begin
        avm_address <= 2'd0;
        is_poll     <= 1'b1;
        lat_cnt     <= '0;
      end else if (state_q == READ) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
      if (last_rd) begin
        if (is_poll) begin
          poll_data    <= avm_readdata[7:0];
          sample_valid <= 1'b1;
          change_pulse <= sample_valid &&
                          (avm_readdata[7:0] != poll_data);
        end else begin
          rsp_readdata <= avm_readdata;
        end
      end
      // an expiry while a poll is still pending simply merges into it
      if (!poll_enable) begin
        poll_cnt     <= RELOAD;
        poll_pending <= 1'b0;
      end else if (poll_cnt == '0) begin
        poll_cnt     <= RELOAD;
        poll_pending <= 1'b1;
      end else begin
        poll_cnt <= poll_cnt - CW'(1);
        if (start_poll) poll_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nios_pio_master.sv
// Directed bench for nios_pio_master with a small nios_pio slave model.
// Latency 1, poll period 8.
module tb_nios_pio_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_address;
  logic [31:0] cmd_writedata;
  logic        rsp_valid;
  logic [31:0] rsp_readdata;
  logic        poll_enable;
  logic [7:0]  poll_data;
  logic        change_pulse;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  logic [7:0]  in_port;
  logic [7:0]  out_port;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int rsps   = 0;

  always #5 clk = ~clk;

  nios_pio_master #(
    .READ_LATENCY(1),
    .POLL_PERIOD (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_address   (cmd_address),
    .cmd_writedata (cmd_writedata),
    .rsp_valid     (rsp_valid),
    .rsp_readdata  (rsp_readdata),
    .poll_enable   (poll_enable),
    .poll_data     (poll_data),
    .change_pulse  (change_pulse),
    .avm_address   (avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_write_n   (avm_write_n),
    .avm_writedata (avm_writedata),
    .avm_readdata  (avm_readdata)
  );

  // PIO slave: addr 0 reads in_port, writes out_port; one-cycle read latency
  always @(posedge clk) begin
    if (reset) begin
      out_port     <= '0;
      avm_readdata <= '0;
    end else begin
      if (avm_chipselect && !avm_write_n && avm_address == 2'd0)
        out_port <= avm_writedata[7:0];
      if (avm_chipselect && avm_write_n)
        avm_readdata <= (avm_address == 2'd0) ? {24'd0, in_port} : 32'd0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    pulses += int'(change_pulse);
    rsps   += int'(rsp_valid);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      edge_();
      sample();
    end
  endtask

  initial begin
    reset         = 1'b1;
    cmd_valid     = 1'b0;
    cmd_write     = 1'b0;
    cmd_address   = 2'd0;
    cmd_writedata = 32'd0;
    poll_enable   = 1'b0;
    in_port       = 8'h00;
    run(2);
    check("rst_ready", cmd_ready, 0);
    check("rst_cs", avm_chipselect, 0);
    check("rst_wn", avm_write_n, 1);
    check("rst_rsp", rsp_valid, 0);
    check("rst_addr", avm_address, 0);
    check("rst_wdata", avm_writedata, 0);
    check("rst_rdata", rsp_readdata, 0);
    check("rst_poll", poll_data, 0);
    check("rst_pulse", change_pulse, 0);
    edge_();
    reset = 1'b0;
    sample();
    check("rel_ready", cmd_ready, 1);

    // write path
    edge_();
    cmd_valid     = 1'b1;
    cmd_write     = 1'b1;
    cmd_address   = 2'd0;
    cmd_writedata = 32'h0000_00A5;
    sample();
    check("wr_c0_ready", cmd_ready, 1);
    edge_();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    sample();
    check("wr_c1_cs", avm_chipselect, 1);
    check("wr_c1_wn", avm_write_n, 0);
    check("wr_c1_addr", avm_address, 0);
    check("wr_c1_wdata", avm_writedata, 32'hA5);
    check("wr_c1_ready", cmd_ready, 0);
    run(1);
    check("wr_c2_ready", cmd_ready, 1);
    check("wr_c2_out", out_port, 8'hA5);
    check("wr_c2_cs", avm_chipselect, 0);
    check("wr_c2_wn", avm_write_n, 1);
    check("wr_c2_hold", avm_writedata, 32'hA5);

    // read path
    edge_();
    in_port     = 8'h3C;
    cmd_valid   = 1'b1;
    cmd_address = 2'd0;
    rsps        = 0;
    sample();
    edge_();
    cmd_valid = 1'b0;
    sample();
    check("rd_c1_cs", avm_chipselect, 1);
    check("rd_c1_wn", avm_write_n, 1);
    check("rd_c1_ready", cmd_ready, 0);
    run(2);
    check("rd_c3_rsp", rsp_valid, 1);
    check("rd_c3_data", rsp_readdata, 32'h0000_003C);
    check("rd_c3_ready", cmd_ready, 0);
    check("rd_c3_cs", avm_chipselect, 0);
    run(1);
    check("rd_c4_ready", cmd_ready, 1);
    check("rd_rsp_count", rsps, 1);

    // unmapped address
    edge_();
    cmd_valid   = 1'b1;
    cmd_address = 2'd2;
    sample();
    edge_();
    cmd_valid = 1'b0;
    sample();
    check("um_addr", avm_address, 2);
    run(2);
    check("um_rsp", rsp_valid, 1);
    check("um_data", rsp_readdata, 0);
    run(1);

    // polling and change detect, enable in cycle E
    edge_();
    poll_enable = 1'b1;
    in_port     = 8'h11;
    pulses      = 0;
    sample();
    run(9);
    check("p1_cs", avm_chipselect, 1);
    check("p1_addr", avm_address, 0);
    run(1);
    check("p1_before", poll_data, 0);
    run(1);
    check("p1_data", poll_data, 8'h11);
    check("p1_nopulse", pulses, 0);
    check("p1_ready", cmd_ready, 1);
    in_port = 8'h22;
    pulses  = 0;
    run(7);
    check("p2_before", poll_data, 8'h11);
    run(1);
    check("p2_pulse", change_pulse, 1);
    check("p2_data", poll_data, 8'h22);
    run(1);
    check("p2_pulse_end", change_pulse, 0);
    check("p2_count", pulses, 1);
    pulses = 0;
    run(8);
    check("p3_data", poll_data, 8'h22);
    check("p3_nopulse", pulses, 0);

    // command arrives in the cycle a poll becomes pending (E+32)
    run(3);
    edge_();
    cmd_valid   = 1'b1;
    cmd_write   = 1'b0;
    cmd_address = 2'd0;
    in_port     = 8'h5A;
    sample();
    check("arb_ready", cmd_ready, 1);
    edge_();
    cmd_valid = 1'b0;
    rsps      = 0;
    pulses    = 0;
    sample();
    check("arb_cmd_cs", avm_chipselect, 1);
    run(2);
    check("arb_rsp", rsp_valid, 1);
    check("arb_rdata", rsp_readdata, 32'h5A);
    check("arb_poll_old", poll_data, 8'h22);
    run(1);
    check("arb_idle", cmd_ready, 1);
    run(1);
    check("arb_poll_cs", avm_chipselect, 1);
    check("arb_poll_rdy", cmd_ready, 0);
    run(2);
    check("arb_pulse", change_pulse, 1);
    check("arb_poll_new", poll_data, 8'h5A);
    check("arb_no_rsp", rsp_valid, 0);
    run(1);
    check("arb_rsp_cnt", rsps, 1);
    check("arb_pulse_cnt", pulses, 1);

    edge_();
    poll_enable = 1'b0;
    sample();
    run(4);

    // reset during the first READ cycle
    edge_();
    cmd_valid   = 1'b1;
    cmd_address = 2'd0;
    poll_enable = 1'b1;
    in_port     = 8'h77;
    sample();
    check("rr_ready", cmd_ready, 1);
    edge_();
    cmd_valid = 1'b0;
    reset     = 1'b1;
    rsps      = 0;
    pulses    = 0;
    sample();
    check("rr_cs_read", avm_chipselect, 1);
    check("rr_ready_rst", cmd_ready, 0);
    edge_();
    reset = 1'b0;
    sample();
    check("rr_cs_idle", avm_chipselect, 0);
    check("rr_wn_idle", avm_write_n, 1);
    check("rr_ready_rel", cmd_ready, 1);
    check("rr_rdata", rsp_readdata, 0);
    check("rr_poll", poll_data, 0);
    run(8);
    check("rr_p_cs_lo", avm_chipselect, 0);
    run(1);
    check("rr_p_cs_hi", avm_chipselect, 1);
    run(1);
    check("rr_p_before", poll_data, 0);
    run(1);
    check("rr_p_data", poll_data, 8'h77);
    check("rr_p_nopulse", change_pulse, 0);
    check("rr_rsp_cnt", rsps, 0);
    check("rr_pulse_cnt", pulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_pio_master.md
# nios_pio_master

Avalon-MM initiator that drives the `nios_pio` register slave from local fabric logic, with no processor involved. It accepts single read/write commands on a valid/ready port and returns read data on a response port. It also polls the PIO input register periodically and flags changes in the sampled value. It sits between user logic and the PIO's `s1` slave port, with the same register map: address 0 holds the data register.

## Interface
Parameters:
- `READ_LATENCY`, 1: slave cycles from address presentation to valid `readdata`; legal range 1..4.
- `POLL_PERIOD`, 1000: clock cycles between automatic polls; must be ≥ `READ_LATENCY`+3.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_address`  in  2  slave register address.
- `cmd_writedata`  in  32  write data.
- `rsp_valid`  out  1  one-cycle pulse; `rsp_readdata` is valid in that cycle.
- `rsp_readdata`  out  32  captured read data; holds its value until the next command read.
- `poll_enable`  in  1  enables automatic polling.
- `poll_data`  out  8  low byte of the most recent poll sample.
- `change_pulse`  out  1  one-cycle pulse when a poll sample differs from the previous one.
- `avm_address`  out  2  Avalon address.
- `avm_chipselect`  out  1  Avalon chipselect.
- `avm_write_n`  out  1  Avalon write strobe, active-low.
- `avm_writedata`  out  32  Avalon write data.
- `avm_readdata`  in  32  Avalon read data.

## Operation
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE:
  - `cmd_ready`=1.
  - Accept on `cmd_valid`&`cmd_ready`: the command's address and data are registered, then go to WRITE if `cmd_write`=1, otherwise READ.
  - Without `cmd_valid`, a set `poll_pending` starts an internal read of address 0 and clears `poll_pending`.
  - A command has priority over a pending poll in the same cycle.
- WRITE: exactly one cycle with `avm_chipselect`=1, `avm_write_n`=0, registered address and data. Then IDLE. Writes produce no response.
- READ:
  - Lasts `READ_LATENCY`+1 cycles with `avm_chipselect`=1, `avm_write_n`=1 and the address held.
  - `avm_readdata` is captured on the last cycle.
  - Command read: capture goes to `rsp_readdata`, then DONE.
  - Poll read: capture goes to `poll_data`, then IDLE with no `rsp_valid`.
- DONE: `rsp_valid`=1 for one cycle, then IDLE.
- Outside WRITE/READ: `avm_chipselect`=0, `avm_write_n`=1; address and writedata hold their last value.
- `cmd_ready`=0 in WRITE, READ and DONE.
- Poll timer:
  - Down-counter, reloaded to `POLL_PERIOD`-1.
  - Decrements while `poll_enable`=1; at 0 it sets `poll_pending` and reloads.
  - An expiry while `poll_pending` is already set is dropped; there is no queueing.
  - `poll_enable`=0 reloads the counter and clears `poll_pending`.
  - An in-flight poll read completes normally when `poll_enable` falls.
- Change detect:
  - The first poll after reset loads `poll_data` and sets `sample_valid`, with no pulse.
  - Each later poll compares the new low byte with `poll_data`; if they differ, `change_pulse`=1 for the cycle after capture.
  - `poll_data` updates on every poll.

## Timing
- Reset values:
  - `cmd_ready`=0 while `reset` is high.
  - `rsp_valid`=0, `rsp_readdata`=0, `poll_data`=0, `change_pulse`=0.
  - `avm_chipselect`=0, `avm_write_n`=1, `avm_address`=0, `avm_writedata`=0.
  - State IDLE, counter reloaded, `poll_pending`=0, `sample_valid`=0.
- First cycle after `reset` deasserts: `cmd_ready`=1.
- Reset mid-transaction aborts the transaction with no response; the Avalon strobes return to idle at the next edge.
- Write accepted in cycle 0: strobe in cycle 1, `cmd_ready`=1 in cycle 2.
- Read accepted in cycle 0:
  - Address and chipselect in cycles 1..`READ_LATENCY`+1; capture at the end of cycle `READ_LATENCY`+1.
  - `rsp_valid` in cycle `READ_LATENCY`+2; `cmd_ready`=1 in cycle `READ_LATENCY`+3.
- Poll started in IDLE cycle P: capture at the end of P+`READ_LATENCY`+1, `change_pulse` at P+`READ_LATENCY`+2, IDLE at P+`READ_LATENCY`+2.

## Test plan
- Write path: reset, then cmd write addr 0 data 0x000000A5 at cycle 0 -> cycle 1 shows chipselect=1, write_n=0, address 0, writedata 0xA5; PIO `out_port`=0xA5 from cycle 2; `cmd_ready`=1 in cycle 2.
- Read path, `READ_LATENCY`=1: `in_port`=0x3C, cmd read addr 0 at cycle 0 -> `rsp_valid` only in cycle 3 with `rsp_readdata`=0x0000003C; `cmd_ready`=1 in cycle 4.
- Read of an unmapped address: cmd read addr 2 -> `rsp_readdata`=0.
- Poll and change detect, `POLL_PERIOD`=8, `poll_enable`=1:
  - `in_port`=0x11 -> first poll gives `poll_data`=0x11, no pulse.
  - Change `in_port` to 0x22 -> next poll gives `poll_data`=0x22 and one `change_pulse`.
  - Unchanged input -> no pulse.
- Arbitration: `cmd_valid` held high in the same cycle `poll_pending` is set -> the command runs first, the poll runs immediately after, and `rsp_valid` fires for the command only.
- Reset in READ state cycle 1 -> no `rsp_valid`; next cycle chipselect=0, write_n=1; after release `cmd_ready`=1 and the poll counter restarts from `POLL_PERIOD`-1.
